// File: rtl/beat_collect_queue.sv
// beat_collect_queue: gathers BEATS input beats of BEAT_W bits into one line,
// then queues each complete line with its tag and cacheable flag in a
// DEPTH-entry in-order queue. The cache fill logic drains that queue with a
// read/valid handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous clear of the queue and any partial line
//   i_vld/i_1st     beat valid / first beat of a line (i_tag, i_ca sampled with it)
//   i_tag, i_ca     line tag and cacheable flag
//   i_data          beat data
//   o_in_rdy        queue can accept beats
//   o_drop          current beat discarded (same-cycle pulse)
//   o_vld, o_data, o_tag, o_ca   head entry
//   read            pop the head (ignored when o_vld=0)
//   o_count         number of complete entries held
module beat_collect_queue #(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned BEATS  = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          i_vld,
  input  logic                          i_1st,
  input  logic [TAG_W-1:0]              i_tag,
  input  logic                          i_ca,
  input  logic [BEAT_W-1:0]             i_data,
  output logic                          o_in_rdy,
  output logic                          o_drop,
  output logic                          o_vld,
  output logic [BEATS*BEAT_W-1:0]       o_data,
  output logic [TAG_W-1:0]              o_tag,
  output logic                          o_ca,
  input  logic                          read,
  output logic [$clog2(DEPTH):0]        o_count
);

  localparam int unsigned LINE_W = BEATS * BEAT_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [LINE_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic              mem_ca   [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic [PTR_W-1:0]  wrptr;
  logic [PTR_W-1:0]  rdptr;
  logic [IDX_W-1:0]  idx;
  logic              open;
  logic [CNT_W-1:0]  count;

  logic              clr;
  logic              beat_ok;
  logic              commit;
  logic              pop;
  logic [IDX_W-1:0]  wr_idx;

  // Event decode; flush/reset override every other event in the cycle.
  always_comb begin
    clr      = rst | flush;
    o_in_rdy = (count != CNT_W'(DEPTH));
    wr_idx   = i_1st ? IDX_W'(0) : idx;
    beat_ok  = ~clr & i_vld & o_in_rdy & (i_1st | open);
    commit   = beat_ok & (wr_idx == IDX_W'(BEATS - 1));
    pop      = ~clr & o_vld & read;
    o_drop   = ~clr & i_vld & (~o_in_rdy | (~i_1st & ~open));
  end

  // Head outputs are a mux of the entry registers at rdptr.
  always_comb begin
    o_vld   = valid[rdptr];
    o_data  = mem_data[rdptr];
    o_tag   = mem_tag[rdptr];
    o_ca    = mem_ca[rdptr];
    o_count = count;
  end

  // Control state: pointers, valids, assembly index, occupancy.
  always_ff @(posedge clk) begin
    if (clr) begin
      wrptr <= '0;
      rdptr <= '0;
      valid <= '0;
      idx   <= '0;
      open  <= 1'b0;
      count <= '0;
    end else begin
      if (beat_ok) begin
        if (commit) begin
          valid[wrptr] <= 1'b1;
          wrptr        <= wrptr + PTR_W'(1);
          open         <= 1'b0;
          idx          <= '0;
        end else begin
          // A first beat restarts the line in the same slot, abandoning any partial.
          open <= 1'b1;
          idx  <= wr_idx + IDX_W'(1);
        end
      end
      if (pop) begin
        valid[rdptr] <= 1'b0;
        rdptr        <= rdptr + PTR_W'(1);
      end
      case ({commit, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; the slot at wrptr is never valid while beats are accepted.
  always_ff @(posedge clk) begin
    if (beat_ok) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (wr_idx == IDX_W'(k)) mem_data[wrptr][k*BEAT_W +: BEAT_W] <= i_data;
      end
      if (i_1st) begin
        mem_tag[wrptr] <= i_tag;
        mem_ca[wrptr]  <= i_ca;
      end
    end
  end

endmodule

// File: tb/tb_beat_collect_queue.sv
// Directed bench for beat_collect_queue (BEAT_W=32, BEATS=2, DEPTH=4, TAG_W=15).
// Stimulus pushes expected lines into a scoreboard; a monitor pops and compares
// whenever a pop handshake is presented.
module tb_beat_collect_queue;

  typedef struct packed {
    logic [63:0] data;
    logic [14:0] tag;
    logic        ca;
  } line_t;

  logic        clk = 1'b0;
  logic        rst, flush, i_vld, i_1st, i_ca, read;
  logic [14:0] i_tag;
  logic [31:0] i_data;
  logic        o_in_rdy, o_drop, o_vld, o_ca;
  logic [63:0] o_data;
  logic [14:0] o_tag;
  logic [2:0]  o_count;

  int tests = 0;
  int fails = 0;
  line_t sb [$];

  beat_collect_queue #(.BEAT_W(32), .BEATS(2), .DEPTH(4), .TAG_W(15)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_vld(i_vld), .i_1st(i_1st), .i_tag(i_tag), .i_ca(i_ca), .i_data(i_data),
    .o_in_rdy(o_in_rdy), .o_drop(o_drop), .o_vld(o_vld), .o_data(o_data),
    .o_tag(o_tag), .o_ca(o_ca), .read(read), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every effective pop is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !flush && read && o_vld) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got tag %h expected no entry", o_tag);
      end else begin
        line_t e;
        e = sb.pop_front();
        chk("pop_data", o_data, e.data);
        chk("pop_tag", 64'(o_tag), 64'(e.tag));
        chk("pop_ca", 64'(o_ca), 64'(e.ca));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic first, input logic [14:0] tag, input logic ca,
                           input logic [31:0] d, input logic exp_drop);
    i_vld = 1'b1; i_1st = first; i_tag = tag; i_ca = ca; i_data = d;
    @(negedge clk);
    chk("drop", 64'(o_drop), 64'(exp_drop));
    step();
    i_vld = 1'b0; i_1st = 1'b0;
  endtask

  task automatic send_line(input logic [14:0] tag, input logic ca,
                           input logic [31:0] d0, input logic [31:0] d1);
    send_beat(1'b1, tag, ca, d0, 1'b0);
    send_beat(1'b0, 15'h0, 1'b0, d1, 1'b0);
    sb.push_back('{data: {d1, d0}, tag: tag, ca: ca});
  endtask

  task automatic pop();
    read = 1'b1;
    @(negedge clk);
    chk("pop_vld", 64'(o_vld), 64'd1);
    step();
    read = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [2:0] cnt,
                           input logic vld, input logic rdy);
    @(negedge clk);
    chk({name, "_count"}, 64'(o_count), 64'(cnt));
    chk({name, "_vld"}, 64'(o_vld), 64'(vld));
    chk({name, "_rdy"}, 64'(o_in_rdy), 64'(rdy));
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; i_vld = 1'b0; i_1st = 1'b0; i_ca = 1'b0;
    i_tag = '0; i_data = '0; read = 1'b0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_drop", 64'(o_drop), 64'd0);
    chk_state("reset", 3'd0, 1'b0, 1'b1);

    // Read with an empty queue is ignored.
    read = 1'b1; step(); read = 1'b0;
    chk_state("empty_read", 3'd0, 1'b0, 1'b1);

    // Basic line, visible the cycle after its last beat.
    send_line(15'h1A3, 1'b1, 32'hAAAA0001, 32'h55550002);
    @(negedge clk);
    chk("basic_data", o_data, 64'h55550002_AAAA0001);
    chk_state("basic", 3'd1, 1'b1, 1'b1);
    pop();
    chk_state("basic_pop", 3'd0, 1'b0, 1'b1);

    // Fill to DEPTH, back-pressure drop, drain in order; twice for wrap.
    for (int r = 0; r < 2; r++) begin
      for (int t = 1; t <= 4; t++)
        send_line(15'(t + 10 * r), 1'(t), 32'(32'hC000_0000 + t), 32'(32'hD000_0000 + t + r));
      chk_state("full", 3'd4, 1'b1, 1'b0);
      send_beat(1'b1, 15'h5, 1'b1, 32'hDEAD0000, 1'b1);
      chk_state("full_drop", 3'd4, 1'b1, 1'b0);
      for (int t = 0; t < 4; t++) pop();
      chk_state("drained", 3'd0, 1'b0, 1'b1);
    end

    // Commit and pop in the same cycle with two entries held.
    send_line(15'h21, 1'b0, 32'h00000021, 32'h10000021);
    send_line(15'h22, 1'b1, 32'h00000022, 32'h10000022);
    send_beat(1'b1, 15'h23, 1'b1, 32'h00000023, 1'b0);
    sb.push_back('{data: 64'h10000023_00000023, tag: 15'h23, ca: 1'b1});
    i_vld = 1'b1; i_1st = 1'b0; i_data = 32'h10000023; read = 1'b1;
    @(negedge clk);
    chk("simul_drop", 64'(o_drop), 64'd0);
    step();
    i_vld = 1'b0; read = 1'b0;
    chk_state("simul", 3'd2, 1'b1, 1'b1);
    pop(); pop();

    // Restart abandons the partial line; orphan non-first beat is dropped.
    send_beat(1'b1, 15'h7, 1'b1, 32'h77777777, 1'b0);
    send_beat(1'b1, 15'h9, 1'b0, 32'h99990000, 1'b0);
    send_beat(1'b0, 15'h0, 1'b1, 32'h99990001, 1'b0);
    sb.push_back('{data: 64'h99990001_99990000, tag: 15'h9, ca: 1'b0});
    chk_state("restart", 3'd1, 1'b1, 1'b1);
    send_beat(1'b0, 15'h0, 1'b0, 32'hBAD00000, 1'b1);
    chk_state("orphan", 3'd1, 1'b1, 1'b1);
    pop();

    // Flush with two entries and a partial line, together with read.
    send_line(15'h31, 1'b1, 32'h00000031, 32'h10000031);
    send_line(15'h32, 1'b0, 32'h00000032, 32'h10000032);
    send_beat(1'b1, 15'h33, 1'b1, 32'h00000033, 1'b0);
    flush = 1'b1; read = 1'b1;
    step();
    flush = 1'b0; read = 1'b0;
    sb.delete();
    chk_state("flush", 3'd0, 1'b0, 1'b1);
    send_beat(1'b0, 15'h0, 1'b0, 32'h10000033, 1'b1);
    chk_state("post_flush", 3'd0, 1'b0, 1'b1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
